// File: rtl/iomem_initiator.sv
// Single-outstanding iomem bus initiator: a cmd stream in, iomem transactions out,
// and one rsp per command carrying the read data or a timeout error.
module iomem_initiator #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        iomem_valid,
   input  logic        iomem_ready,
   output logic [3:0]  iomem_wstrb,
   output logic [31:0] iomem_addr,
   output logic [31:0] iomem_wdata,
   input  logic [31:0] iomem_rdata,
   output logic        busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUS  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == BUS) || (state == RESP);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         iomem_valid <= 1'b0;
         iomem_wstrb <= '0;
         iomem_addr  <= '0;
         iomem_wdata <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  iomem_addr  <= cmd_addr;
                  iomem_wdata <= cmd_wdata;
                  iomem_wstrb <= cmd_wstrb;
                  iomem_valid <= 1'b1;
                  cnt         <= '0;
                  state       <= BUS;
               end
            end
            BUS: begin
               // ready is tested first so a completion on the last allowed cycle is a success
               if (iomem_ready) begin
                  rsp_rdata   <= iomem_rdata;
                  rsp_err     <= 1'b0;
                  iomem_valid <= 1'b0;
                  iomem_wstrb <= '0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else if (cnt == CNT_LAST) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  iomem_valid <= 1'b0;
                  iomem_wstrb <= '0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iomem_initiator.sv
// Bench for iomem_initiator: bench-side responder with per-transaction latency and a
// timeline model predicting every output each cycle, plus directed literal checks.
module tb_iomem_initiator;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        iomem_valid;
   logic        iomem_ready = 1'b0;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata = '0;
   logic        busy;

   iomem_initiator #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
      .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // responder state
   logic [31:0] resp_mem [16];
   int          r_age = 0;
   int          txn_cnt = 0;
   int          vcount = 0;
   bit          spur_en = 1'b1;
   int          cur_delay = 0;

   // model state
   logic [31:0] model_mem [16];
   bit          model_valid = 1'b0;
   int          cyc = 0;
   bit          m_txn = 1'b0;
   bit          m_rsp = 1'b0;
   int          m_E = 0;
   int          m_d = 0;
   int          m_acc = 0;
   logic [3:0]  m_idx = '0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_wstrb = '0;
   logic [31:0] m_exp_rdata = '0;
   logic [31:0] m_rsp_rdata = '0;
   logic        m_rsp_err = 1'b0;

   logic [32:0] got_q [$];

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] w, logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = w[8*b +: 8];
      return r;
   endfunction

   function automatic int pick_delay();
      int r;
      r = int'($urandom % 10);
      case (r)
         6: return T - 2;
         7: return T - 1;
         8: return T;
         9: return T + 5;
         default: return int'($urandom % 4);
      endcase
   endfunction

   // One clock: responder reacts, model advances over the edge, outputs compared after it.
   task automatic step();
      logic [3:0] ridx;
      int         e;
      iomem_ready = 1'b0;
      iomem_rdata = $urandom;
      if (iomem_valid === 1'b1) begin
         if (r_age == m_d) begin
            ridx        = iomem_addr[5:2];
            iomem_ready = 1'b1;
            iomem_rdata = resp_mem[ridx];
            if (resetn) begin
               txn_cnt++;
               if (iomem_wstrb != 4'b0000)
                  resp_mem[ridx] = merge(resp_mem[ridx], iomem_wdata, iomem_wstrb);
            end
         end
         r_age++;
      end else begin
         r_age = 0;
         iomem_ready = spur_en && ($urandom % 3 == 0);
      end
      if (rsp_valid === 1'b1 && rsp_ready && resetn)
         got_q.push_back({rsp_err, rsp_rdata});

      e = cyc + 1;
      if (!resetn) begin
         model_valid = 1'b1;
         m_txn = 1'b0; m_rsp = 1'b0;
         m_addr = '0; m_wdata = '0; m_wstrb = '0;
         m_rsp_rdata = '0; m_rsp_err = 1'b0;
      end else if (model_valid) begin
         if (m_txn) begin
            if (e == m_E) begin
               m_txn = 1'b0;
               m_rsp = 1'b1;
               if (m_d < T) begin
                  m_rsp_rdata = m_exp_rdata;
                  m_rsp_err   = 1'b0;
                  if (m_wstrb != 4'b0000)
                     model_mem[m_idx] = merge(model_mem[m_idx], m_wdata, m_wstrb);
               end else begin
                  m_rsp_rdata = '0;
                  m_rsp_err   = 1'b1;
               end
            end
         end else if (m_rsp) begin
            if (rsp_ready) m_rsp = 1'b0;
         end else if (cmd_valid) begin
            m_txn = 1'b1;
            m_addr = cmd_addr; m_wdata = cmd_wdata; m_wstrb = cmd_wstrb;
            m_idx = cmd_addr[5:2];
            m_d = cur_delay;
            m_E = (m_d < T) ? e + 1 + m_d : e + T;
            m_exp_rdata = model_mem[m_idx];
            m_acc++;
         end
      end
      cyc = e;

      @(posedge clk);
      @(negedge clk);
      if (iomem_valid === 1'b1) vcount++;
      if (model_valid) begin
         chk("cmd_ready", 32'(cmd_ready), 32'(!m_txn && !m_rsp));
         chk("busy", 32'(busy), 32'(m_txn || m_rsp));
         chk("iomem_valid", 32'(iomem_valid), 32'(m_txn));
         chk("iomem_wstrb", 32'(iomem_wstrb), m_txn ? 32'(m_wstrb) : 32'd0);
         chk("iomem_addr", iomem_addr, m_addr);
         chk("iomem_wdata", iomem_wdata, m_wdata);
         chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
         if (m_rsp) begin
            chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
            chk("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
         end
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s, input int dly);
      int n0;
      n0 = m_acc;
      cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = w; cmd_wstrb = s; cur_delay = dly;
      for (int i = 0; i < 100 && m_acc == n0; i++) step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int n);
      for (int i = 0; i < 200 && got_q.size() < n; i++) step();
      chk("rsp_count", got_q.size(), n);
   endtask

   task automatic new_cmd();
      logic [3:0] idx;
      idx = 4'($urandom);
      cmd_addr  = 32'h0300_0000 | (32'(idx) << 2);
      cmd_wdata = $urandom;
      cmd_wstrb = ($urandom % 4 == 0) ? 4'b0000 : 4'($urandom);
      cur_delay = pick_delay();
      cmd_valid = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      for (int i = 0; i < 16; i++) begin
         resp_mem[i]  = (i == 0) ? 32'h0 : 32'hC0DE_0000 + 32'(i);
         model_mem[i] = (i == 0) ? 32'h0 : 32'hC0DE_0000 + 32'(i);
      end
      @(negedge clk);
      step();
      step();
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("reset_iomem_valid", 32'(iomem_valid), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_iomem_addr", iomem_addr, 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      resetn = 1'b1;

      // GPIO write then read back
      rsp_ready = 1'b1;
      issue(32'h0300_0000, 32'h0000_00A5, 4'b0001, 1);
      wait_rsp(1);
      chk("t1_txn_cnt", txn_cnt, 1);
      chk("t1_gpio", resp_mem[0], 32'h0000_00A5);
      chk("t1_err", 32'(got_q[0][32]), 32'd0);
      issue(32'h0300_0000, 32'h0, 4'b0000, 2);
      wait_rsp(2);
      chk("t2_rdata", got_q[1][31:0], 32'h0000_00A5);
      chk("t2_err", 32'(got_q[1][32]), 32'd0);

      // responder that never answers
      vcount = 0;
      issue(32'h0300_0014, 32'hDEAD_BEEF, 4'b1111, T + 5);
      wait_rsp(3);
      chk("t3_valid_cycles", vcount, 16);
      chk("t3_err", 32'(got_q[2][32]), 32'd1);
      chk("t3_rdata", got_q[2][31:0], 32'd0);
      chk("t3_mem_untouched", resp_mem[5], 32'hC0DE_0005);

      // response back-pressure
      rsp_ready = 1'b0;
      issue(32'h0300_000C, 32'h0, 4'b0000, 2);
      for (int i = 0; i < 40 && !m_rsp; i++) step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("t4_busy", 32'(busy), 32'd1);
         chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("t4_rdata", rsp_rdata, 32'hC0DE_0003);
      end
      rsp_ready = 1'b1;
      wait_rsp(4);

      // reset while on the bus
      issue(32'h0300_0010, 32'h0, 4'b0000, T + 5);
      step(); step();
      resetn = 1'b0;
      step();
      chk("t5_iomem_valid", 32'(iomem_valid), 32'd0);
      chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
      end
      chk("t5_rsp_count", got_q.size(), 4);

      // two queued commands with cmd_valid held
      n0 = got_q.size();
      issue(32'h0300_0008, 32'h1234_5678, 4'b1111, 1);
      issue(32'h0300_0008, 32'h0, 4'b0000, 0);
      wait_rsp(n0 + 2);
      chk("t6_first", got_q[n0], {1'b0, 32'hC0DE_0002});
      chk("t6_second", got_q[n0 + 1], {1'b0, 32'h1234_5678});

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (!cmd_valid && $urandom % 2 == 0) new_cmd();
         rsp_ready = ($urandom % 4 != 0);
         resetn    = ($urandom % 300 != 0);
         n0 = m_acc;
         step();
         if (m_acc != n0) begin
            if ($urandom % 2 == 0) new_cmd();
            else cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      resetn = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 40; i++) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
